data_mem_responder: RTL

Data-memory target for miniRV load/store traffic (lw, lbu, sw, sb). It is the responder end of the core's data-memory request/response handshake. It accepts one request at a time over a valid/ready channel and performs the access after a programmable wait latency. It then holds the response until the core accepts it.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for miniRV load/store traffic with a programmable access latency.
// Optional build macro DMEM_BACK2BACK_EN lets a new request be accepted on the edge a response retires.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic              accept, retire, access, acc_err;
  logic [31:0]       off, word, rd_val;
  logic [7:0]        lane;
  logic [IDX_W-1:0]  idx;

  // Offsets below BASE_ADDR wrap to large values and fall out of range naturally.
  assign off     = cap_addr - BASE_ADDR;
  assign idx     = off[IDX_W+1:2];
  assign acc_err = cap_size[0] | (cap_size[1] & (cap_addr[1:0] != 2'b00)) | (off >= SPAN);
  assign word    = mem[idx];

  always_comb begin
    lane = word[7:0];
    case (cap_addr[1:0])
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      2'd3:    lane = word[31:24];
      default: lane = word[7:0];
    endcase
  end

  always_comb begin
    rd_val = 32'd0;
    if (!acc_err && !cap_we)
      rd_val = cap_size[1] ? word : {24'd0, lane};
  end

  assign retire    = (state == RESP) && rsp_ready;
  assign access    = (state == WAIT) && (cnt == 4'd1);
  assign rsp_valid = (state == RESP);
`ifdef DMEM_BACK2BACK_EN
  assign req_ready = rst && ((state == IDLE) || retire);
`else
  assign req_ready = rst && (state == IDLE);
`endif
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (retire) state_nxt = accept ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_size  <= 2'b00;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= LAT;
        cap_we    <= req_we;
        cap_size  <= req_size;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_rdata <= rd_val;
        rsp_err   <= acc_err;
      end else if (retire) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; writes only occur on the access edge of a live transaction.
  always_ff @(posedge clk) begin
    if (access && cap_we && !acc_err) begin
      if (cap_size[1]) begin
        mem[idx] <= cap_wdata;
      end else begin
        case (cap_addr[1:0])
          2'd0:    mem[idx][7:0]   <= cap_wdata[7:0];
          2'd1:    mem[idx][15:8]  <= cap_wdata[7:0];
          2'd2:    mem[idx][23:16] <= cap_wdata[7:0];
          default: mem[idx][31:24] <= cap_wdata[7:0];
        endcase
      end
    end
  end

endmodule
